// File: rtl/dram_rd_arb.sv
// Two-requester AXI read-channel arbiter for the dram read port.
// Requesters are granted round-robin and only one burst is in flight at a time.
// The grant is held from AR acceptance until the last R beat completes.
// The number of R beats is compared with the registered arlen, and any mismatch sets a sticky error.
// Handshake rule on every channel: a transfer happens on a rising clk edge where valid and ready are both high.
// Once valid is raised it is held, with its payload stable, until that transfer happens.
module dram_rd_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int ID_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ID_WIDTH-1:0]   s0_axi_arid,
   input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
   input  logic [7:0]            s0_axi_arlen,
   input  logic [2:0]            s0_axi_arsize,
   input  logic [1:0]            s0_axi_arburst,
   input  logic                  s0_axi_arvalid,
   output logic                  s0_axi_arready,
   output logic [ID_WIDTH-1:0]   s0_axi_rid,
   output logic [DATA_WIDTH-1:0] s0_axi_rdata,
   output logic [1:0]            s0_axi_rresp,
   output logic                  s0_axi_rlast,
   output logic                  s0_axi_rvalid,
   input  logic                  s0_axi_rready,
   input  logic [ID_WIDTH-1:0]   s1_axi_arid,
   input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
   input  logic [7:0]            s1_axi_arlen,
   input  logic [2:0]            s1_axi_arsize,
   input  logic [1:0]            s1_axi_arburst,
   input  logic                  s1_axi_arvalid,
   output logic                  s1_axi_arready,
   output logic [ID_WIDTH-1:0]   s1_axi_rid,
   output logic [DATA_WIDTH-1:0] s1_axi_rdata,
   output logic [1:0]            s1_axi_rresp,
   output logic                  s1_axi_rlast,
   output logic                  s1_axi_rvalid,
   input  logic                  s1_axi_rready,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   output logic                  busy,
   output logic                  gnt,
   output logic                  beat_err
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t                state, state_nxt;
   logic                  last_win;
   logic                  gnt_r;
   logic                  beat_err_r;
   logic [8:0]            beat_cnt;
   logic [ID_WIDTH-1:0]   ar_id;
   logic [ADDR_WIDTH-1:0] ar_addr;
   logic [7:0]            ar_len;
   logic [2:0]            ar_size;
   logic [1:0]            ar_burst;

   logic req_any, sel, ar_take, in_data, r_hs, len_hit, fwd0, fwd1;

   // Grant choice: when both requesters ask, the one that did not win last time is chosen.
   assign req_any = s0_axi_arvalid | s1_axi_arvalid;
   assign sel     = (s0_axi_arvalid & s1_axi_arvalid) ? ~last_win : s1_axi_arvalid;
   assign ar_take = (state == IDLE) & req_any & ~rst;
   assign s0_axi_arready = ar_take & ~sel;
   assign s1_axi_arready = ar_take & sel;

   assign in_data = (state == DATA);
   assign fwd0    = in_data & ~gnt_r;
   assign fwd1    = in_data & gnt_r;
   assign r_hs    = in_data & m_axi_rvalid & m_axi_rready;
   assign len_hit = (beat_cnt == {1'b0, ar_len});

   // The AR channel to the dram always shows the register; it is qualified by the ADDR state.
   assign m_axi_arvalid = (state == ADDR);
   assign m_axi_arid    = ar_id;
   assign m_axi_araddr  = ar_addr;
   assign m_axi_arlen   = ar_len;
   assign m_axi_arsize  = ar_size;
   assign m_axi_arburst = ar_burst;

   // R pass-through goes to the granted requester only; the other requester sees zeros.
   assign m_axi_rready  = in_data & (gnt_r ? s1_axi_rready : s0_axi_rready);
   assign s0_axi_rvalid = fwd0 & m_axi_rvalid;
   assign s0_axi_rid    = fwd0 ? m_axi_rid   : '0;
   assign s0_axi_rdata  = fwd0 ? m_axi_rdata : '0;
   assign s0_axi_rresp  = fwd0 ? m_axi_rresp : '0;
   assign s0_axi_rlast  = fwd0 & m_axi_rlast;
   assign s1_axi_rvalid = fwd1 & m_axi_rvalid;
   assign s1_axi_rid    = fwd1 ? m_axi_rid   : '0;
   assign s1_axi_rdata  = fwd1 ? m_axi_rdata : '0;
   assign s1_axi_rresp  = fwd1 ? m_axi_rresp : '0;
   assign s1_axi_rlast  = fwd1 & m_axi_rlast;

   assign busy     = (state != IDLE);
   assign gnt      = gnt_r;
   assign beat_err = beat_err_r;

   // Next-state logic: IDLE -> ADDR on AR acceptance, ADDR -> DATA on the dram AR handshake, DATA -> IDLE on the last beat.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ar_take) state_nxt = ADDR;
         ADDR:    if (m_axi_arready) state_nxt = DATA;
         DATA:    if (r_hs && m_axi_rlast) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset abandons any burst in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // On AR acceptance, capture the winner's request and grant, and restart the beat count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_win <= 1'b1;
         gnt_r    <= 1'b0;
         ar_id    <= '0;
         ar_addr  <= '0;
         ar_len   <= '0;
         ar_size  <= '0;
         ar_burst <= '0;
      end else if (ar_take) begin
         last_win <= sel;
         gnt_r    <= sel;
         ar_id    <= sel ? s1_axi_arid    : s0_axi_arid;
         ar_addr  <= sel ? s1_axi_araddr  : s0_axi_araddr;
         ar_len   <= sel ? s1_axi_arlen   : s0_axi_arlen;
         ar_size  <= sel ? s1_axi_arsize  : s0_axi_arsize;
         ar_burst <= sel ? s1_axi_arburst : s0_axi_arburst;
      end
   end

   // Count R beats; flag an early rlast, or a missing rlast once the count reaches arlen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt   <= '0;
         beat_err_r <= 1'b0;
      end else if (ar_take) begin
         beat_cnt <= '0;
      end else if (r_hs) begin
         beat_cnt <= beat_cnt + 9'd1;
         if ((m_axi_rlast && !len_hit) || (!m_axi_rlast && len_hit))
            beat_err_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dram_rd_arb.sv
// Bench for dram_rd_arb.
// It contains requester drivers, a behavioural dram model, a grant/R-beat monitor with per-requester expected queues,
// a set of directed scenarios, and a randomized contention phase.
module tb_dram_rd_arb;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam int IW = 8;
   localparam int EW = IW + DW + 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [IW-1:0] s_arid [2];
   logic [AW-1:0] s_araddr [2];
   logic [7:0]    s_arlen [2];
   logic [2:0]    s_arsize [2];
   logic [1:0]    s_arburst [2];
   logic          s_arvalid [2];
   logic          s_arready [2];
   logic [IW-1:0] s_rid [2];
   logic [DW-1:0] s_rdata [2];
   logic [1:0]    s_rresp [2];
   logic          s_rlast [2];
   logic          s_rvalid [2];
   logic          s_rready [2];
   logic          stall [2];

   logic [IW-1:0] m_arid;
   logic [AW-1:0] m_araddr;
   logic [7:0]    m_arlen;
   logic [2:0]    m_arsize;
   logic [1:0]    m_arburst;
   logic          m_arvalid, m_arready;
   logic [IW-1:0] m_rid;
   logic [DW-1:0] m_rdata;
   logic [1:0]    m_rresp;
   logic          m_rlast, m_rvalid, m_rready;
   logic          busy, gnt, beat_err;

   dram_rd_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
      .clk(clk), .rst(rst),
      .s0_axi_arid(s_arid[0]), .s0_axi_araddr(s_araddr[0]), .s0_axi_arlen(s_arlen[0]),
      .s0_axi_arsize(s_arsize[0]), .s0_axi_arburst(s_arburst[0]), .s0_axi_arvalid(s_arvalid[0]),
      .s0_axi_arready(s_arready[0]), .s0_axi_rid(s_rid[0]), .s0_axi_rdata(s_rdata[0]),
      .s0_axi_rresp(s_rresp[0]), .s0_axi_rlast(s_rlast[0]), .s0_axi_rvalid(s_rvalid[0]),
      .s0_axi_rready(s_rready[0]),
      .s1_axi_arid(s_arid[1]), .s1_axi_araddr(s_araddr[1]), .s1_axi_arlen(s_arlen[1]),
      .s1_axi_arsize(s_arsize[1]), .s1_axi_arburst(s_arburst[1]), .s1_axi_arvalid(s_arvalid[1]),
      .s1_axi_arready(s_arready[1]), .s1_axi_rid(s_rid[1]), .s1_axi_rdata(s_rdata[1]),
      .s1_axi_rresp(s_rresp[1]), .s1_axi_rlast(s_rlast[1]), .s1_axi_rvalid(s_rvalid[1]),
      .s1_axi_rready(s_rready[1]),
      .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize),
      .m_axi_arburst(m_arburst), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
      .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
      .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
      .busy(busy), .gnt(gnt), .beat_err(beat_err)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Dram contents: a fixed function of address and beat index.
   function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a, input int b);
      logic [7:0] b8;
      b8 = 8'(b);
      return {a ^ 16'h5a5a, b8, a[7:0] + b8};
   endfunction

   function automatic logic [1:0] mem_resp(input logic [AW-1:0] a, input int b);
      return (a[4] && b == 1) ? 2'b10 : 2'b00;
   endfunction

   logic [EW-1:0] exp_q0[$];
   logic [EW-1:0] exp_q1[$];
   int            grant_log[$];

   // ---------------- requester driver ----------------
   task automatic push_exp(input int n, input logic [IW-1:0] id, input logic [AW-1:0] addr, input int nb);
      logic [EW-1:0] w;
      for (int b = 0; b < nb; b++) begin
         w = {id, mem_data(addr, b), mem_resp(addr, b), (b == nb - 1)};
         if (n == 0) exp_q0.push_back(w);
         else        exp_q1.push_back(w);
      end
   endtask

   // Called on a negedge; returns on the negedge after the AR handshake.
   task automatic issue(input int n, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                        input logic [7:0] len, input int nb);
      logic acc;
      s_arid[n]    = id;
      s_araddr[n]  = addr;
      s_arlen[n]   = len;
      s_arsize[n]  = 3'd2;
      s_arburst[n] = 2'b01;
      s_arvalid[n] = 1'b1;
      push_exp(n, id, addr, nb);
      acc = 1'b0;
      for (int c = 0; c < 400 && !acc; c++) begin
         #2;
         if (s_arready[n]) acc = 1'b1;
         @(negedge clk);
      end
      if (!acc) check("ar_accept_timeout", 64'd0, 64'd1);
      s_arvalid[n] = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      logic ok;
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         #3;
         if (exp_q0.size() == 0 && exp_q1.size() == 0 && !busy) ok = 1'b1;
      end
      if (!ok) check("drain_timeout", 64'd0, 64'd1);
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Random R back-pressure from both requesters; stall forces rready low.
   initial begin
      s_rready[0] = 1'b0;
      s_rready[1] = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         for (int i = 0; i < 2; i++) s_rready[i] = stall[i] ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- dram model ----------------
   int            d_force_nb;
   int            d_st, d_beat, d_nb;
   logic [IW-1:0] d_id;
   logic [AW-1:0] d_addr;
   logic          ar_hs_d, r_hs_d;

   initial begin
      m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
      d_st = 0; d_beat = 0; d_nb = 0; d_id = '0; d_addr = '0; ar_hs_d = 1'b0; r_hs_d = 1'b0;
      forever begin
         @(negedge clk);
         if (ar_hs_d) d_st = 1;
         if (r_hs_d) begin
            d_beat++;
            m_rvalid = 1'b0;
            if (d_beat == d_nb) d_st = 0;
         end
         m_arready = (d_st == 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
         if (d_st == 1 && !m_rvalid && $urandom_range(0, 3) != 0) begin
            m_rvalid = 1'b1;
            m_rid    = d_id;
            m_rdata  = mem_data(d_addr, d_beat);
            m_rresp  = mem_resp(d_addr, d_beat);
            m_rlast  = (d_beat == d_nb - 1);
         end
         #2;
         if (rst) begin
            m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
            d_st = 0; ar_hs_d = 1'b0; r_hs_d = 1'b0;
         end else begin
            ar_hs_d = m_arvalid & m_arready;
            r_hs_d  = m_rvalid & m_rready;
            if (ar_hs_d) begin
               d_id   = m_arid;
               d_addr = m_araddr;
               d_nb   = (d_force_nb != 0) ? d_force_nb : int'(m_arlen) + 1;
               d_force_nb = 0;
               d_beat = 0;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic          model_last, chk_ar, chk_idle, exp_g, g0, g1, eg;
   logic [IW-1:0] ea_id;
   logic [AW-1:0] ea_addr;
   logic [7:0]    ea_len;
   logic [EW-1:0] w_exp, w_act;

   initial begin
      model_last = 1'b1; chk_ar = 1'b0; chk_idle = 1'b0; exp_g = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            model_last = 1'b1; chk_ar = 1'b0; chk_idle = 1'b0;
            exp_q0.delete();
            exp_q1.delete();
         end else begin
            if (chk_ar) begin
               check("m_arvalid_latency", 64'(m_arvalid), 64'd1);
               check("m_araddr", 64'(m_araddr), 64'(ea_addr));
               check("m_arlen", 64'(m_arlen), 64'(ea_len));
               check("m_arid", 64'(m_arid), 64'(ea_id));
               check("gnt", 64'(gnt), 64'(exp_g));
               check("busy_in_addr", 64'(busy), 64'd1);
               chk_ar = 1'b0;
            end
            if (chk_idle) begin
               check("busy_after_rlast", 64'(busy), 64'd0);
               chk_idle = 1'b0;
            end
            g0 = s_arvalid[0] & s_arready[0];
            g1 = s_arvalid[1] & s_arready[1];
            if (!busy && (s_arvalid[0] || s_arvalid[1])) begin
               eg = (s_arvalid[0] && s_arvalid[1]) ? !model_last : s_arvalid[1];
               check("grant_idx", 64'({g1, g0}), eg ? 64'd2 : 64'd1);
               model_last = eg;
               exp_g   = eg;
               ea_id   = s_arid[eg];
               ea_addr = s_araddr[eg];
               ea_len  = s_arlen[eg];
               chk_ar  = 1'b1;
               grant_log.push_back(int'(eg));
            end else begin
               check("arready_no_grant", 64'({s_arready[1], s_arready[0]}), 64'd0);
            end
            check("rvalid_both", 64'(s_rvalid[0] & s_rvalid[1]), 64'd0);
            if (!s_rready[0] && !s_rready[1]) check("m_rready_no_sink", 64'(m_rready), 64'd0);
            for (int n = 0; n < 2; n++) begin
               if (s_rvalid[n] && s_rready[n]) begin
                  w_act = {s_rid[n], s_rdata[n], s_rresp[n], s_rlast[n]};
                  if ((n == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                     check(n == 0 ? "rbeat_s0_unexpected" : "rbeat_s1_unexpected", 64'd1, 64'd0);
                  end else begin
                     w_exp = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                     check(n == 0 ? "rbeat_s0" : "rbeat_s1", 64'(w_act), 64'(w_exp));
                  end
                  if (s_rlast[n]) chk_idle = 1'b1;
               end
            end
         end
      end
   end

   // ---------------- directed and random scenarios ----------------
   initial begin
      rst = 1'b1;
      d_force_nb = 0;
      for (int i = 0; i < 2; i++) begin
         s_arid[i] = '0; s_araddr[i] = '0; s_arlen[i] = '0; s_arsize[i] = '0; s_arburst[i] = '0;
         s_arvalid[i] = 1'b0; stall[i] = 1'b0;
      end
      s_arvalid[0] = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_gnt", 64'(gnt), 64'd0);
      check("rst_beat_err", 64'(beat_err), 64'd0);
      check("rst_m_arvalid", 64'(m_arvalid), 64'd0);
      check("rst_m_rready", 64'(m_rready), 64'd0);
      check("rst_s0_arready_gated", 64'(s_arready[0]), 64'd0);
      s_arvalid[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // s0 alone, 4-beat burst
      issue(0, 8'h11, 16'h0040, 8'd3, 4);
      wait_idle(300);
      check("t1_beat_err", 64'(beat_err), 64'd0);

      // simultaneous requests right after reset: s0 then s1
      pulse_reset();
      grant_log.delete();
      fork
         issue(0, 8'h21, 16'h0100, 8'd1, 2);
         issue(1, 8'h22, 16'h0200, 8'd2, 3);
      join
      wait_idle(300);
      check("t2_grant_count", 64'(grant_log.size()), 64'd2);
      if (grant_log.size() == 2) begin
         check("t2_first", 64'(grant_log[0]), 64'd0);
         check("t2_second", 64'(grant_log[1]), 64'd1);
      end

      // continuous contention, single-beat bursts
      grant_log.delete();
      fork
         for (int k = 0; k < 4; k++) issue(0, 8'(8'h30 + k), 16'(16'h0300 + k * 16), 8'd0, 1);
         for (int k = 0; k < 4; k++) issue(1, 8'(8'h40 + k), 16'(16'h0400 + k * 16), 8'd0, 1);
      join
      wait_idle(300);
      check("t3_grant_count", 64'(grant_log.size()), 64'd8);
      for (int k = 0; k < grant_log.size() && k < 8; k++) check("t3_alternate", 64'(grant_log[k]), 64'(k % 2));

      // s1 back-pressure mid-burst
      issue(1, 8'h51, 16'h0510, 8'd7, 8);
      for (int c = 0; c < 300 && exp_q1.size() > 6; c++) begin
         @(negedge clk);
         #3;
      end
      @(negedge clk);
      stall[1] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #3;
         check("t4_m_rready_stalled", 64'(m_rready), 64'd0);
         check("t4_s0_rvalid", 64'(s_rvalid[0]), 64'd0);
         check("t4_s1_rvalid_pass", 64'(s_rvalid[1]), 64'(m_rvalid));
         @(negedge clk);
      end
      stall[1] = 1'b0;
      wait_idle(300);

      // dram ends an arlen=3 burst after 3 beats
      check("t5_err_before", 64'(beat_err), 64'd0);
      d_force_nb = 3;
      issue(0, 8'h61, 16'h0610, 8'd3, 3);
      wait_idle(300);
      check("t5_err_short", 64'(beat_err), 64'd1);
      issue(1, 8'h62, 16'h0620, 8'd2, 3);
      wait_idle(300);
      check("t5_err_sticky", 64'(beat_err), 64'd1);

      // reset after the first beat of an 8-beat burst
      issue(1, 8'h71, 16'h0700, 8'd7, 8);
      for (int c = 0; c < 300 && exp_q1.size() > 7; c++) begin
         @(negedge clk);
         #3;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_m_arvalid", 64'(m_arvalid), 64'd0);
      check("t6_m_rready", 64'(m_rready), 64'd0);
      check("t6_s1_rvalid", 64'(s_rvalid[1]), 64'd0);
      check("t6_gnt", 64'(gnt), 64'd0);
      check("t6_beat_err", 64'(beat_err), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      issue(1, 8'h72, 16'h0720, 8'd2, 3);
      wait_idle(300);
      check("t6_err_after", 64'(beat_err), 64'd0);

      // dram keeps going past arlen without rlast
      d_force_nb = 3;
      issue(0, 8'h81, 16'h0800, 8'd1, 3);
      wait_idle(300);
      check("t7_err_overrun", 64'(beat_err), 64'd1);

      // randomized contention
      fork
         for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(0, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)),
                  8'(k % 8), (k % 8) + 1);
         end
         for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(1, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)),
                  8'(7 - k), 8 - k);
         end
      join
      wait_idle(3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dram_rd_arb.md
Name: dram_rd_arb

Overview:
- Two-requester AXI read-channel arbiter in front of the dram block (axi_fifo + axi_ram).
- Shares the single dram read port between the CPU-side master (s0) and the prefetcher (s1).
- Round-robin grant; one burst in flight at a time; the grant is held from AR acceptance until the last R beat completes.
- Also checks the dram's beat count against the requested arlen.

Parameters:
- DATA_WIDTH, 32, R data width in bits.
- ADDR_WIDTH, 16, AR address width in bits.
- ID_WIDTH, 8, AR/R ID width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- sN_axi_arid  in  ID_WIDTH  requester N read ID (N = 0, 1; every sN port below exists for both)
- sN_axi_araddr  in  ADDR_WIDTH  requester N address
- sN_axi_arlen  in  8  requester N burst length minus 1
- sN_axi_arsize  in  3  requester N beat size
- sN_axi_arburst  in  2  requester N burst type
- sN_axi_arvalid  in  1  requester N AR valid
- sN_axi_arready  out  1  requester N AR ready
- sN_axi_rid  out  ID_WIDTH  R ID to requester N
- sN_axi_rdata  out  DATA_WIDTH  R data to requester N
- sN_axi_rresp  out  2  R response to requester N
- sN_axi_rlast  out  1  R last to requester N
- sN_axi_rvalid  out  1  R valid to requester N
- sN_axi_rready  in  1  R ready from requester N
- m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst  out  as s-side  AR to dram
- m_axi_arvalid  out  1  AR valid to dram
- m_axi_arready  in  1  AR ready from dram
- m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid  in  as s-side  R from dram
- m_axi_rready  out  1  R ready to dram
- busy  out  1  high when state is not IDLE
- gnt  out  1  index of the current or most recent grant
- beat_err  out  1  sticky; set on a beat-count mismatch

Behaviour:

States: IDLE, ADDR, DATA. Reset (async) forces:
- state = IDLE, last winner = 1 (so s0 has priority first), gnt = 0, beat_err = 0, beat counter = 0, AR register = 0.
- All sN_arready, sN_rvalid, m_axi_arvalid and m_axi_rready at 0. sN_arready is additionally gated low while rst is high.

IDLE:
- Grant choice:
  - Only one arvalid high: grant that requester.
  - Both high: grant the requester that is not the last winner.
  - Neither high: no grant.
- sG_arready = 1 combinationally for the granted G only.
- On sG_arvalid & sG_arready:
  - capture id/addr/len/size/burst into the AR register;
  - gnt <= G, last winner <= G, beat counter <= 0;
  - next state ADDR.
- One-cycle AR acceptance latency.

ADDR:
- m_axi_arvalid = 1; m_axi_ar* driven from the register, stable until handshake.
- All sN_arready = 0.
- On m_axi_arready, go to DATA.

DATA:
- Combinational R pass-through to the granted requester:
  - sG_axi_r* = m_axi_r*, sG_rvalid = m_axi_rvalid, m_axi_rready = sG_rready.
  - The non-granted requester sees rvalid = 0; its r* outputs hold 0.
- No added latency.
- Each R handshake increments the beat counter (9 bits).
- On a handshake with rlast:
  - if counter != registered arlen, set beat_err;
  - next state IDLE.
- On a handshake where counter == arlen and rlast = 0, set beat_err and keep forwarding until rlast.
- The next AR may be granted in the cycle after the rlast handshake (IDLE, one dead cycle minimum).

Boundary and ordering rules:
- R beats arriving while not in DATA are not accepted: m_axi_rready = 0.
- An sN_arvalid arriving while busy waits; no AR is dropped.
- Under continuous contention, grants alternate strictly s0, s1, s0, ...
- rresp is passed through unchanged; SLVERR does not affect arbitration.
- An AR held valid by one requester does not block the other beyond one burst.
- Reset mid-burst returns to IDLE immediately. The in-flight burst is abandoned; the dram must be reset together with this block.
- beat_err clears only on reset.

Test Plan:
- s0 alone, araddr=0x0040, arlen=3 -> s0_arready high in cycle 0; m_axi_arvalid the next cycle with addr 0x0040, len 3; 4 beats to s0, rlast on the 4th; busy falls after rlast; beat_err=0.
- s0 and s1 assert arvalid in the same cycle after reset -> s0 granted first; s1 granted in the IDLE cycle after s0's rlast; gnt sequence 0, 1.
- Both requesters hold arvalid for 4 bursts each with arlen=0 -> grants alternate 0,1,0,1,0,1,0,1; no requester starves.
- s1 holds rready=0 for 5 cycles mid-burst -> m_axi_rready=0 and dram data held; s0_rvalid stays 0 throughout.
- Dram model returns rlast on beat 2 of an arlen=3 burst -> beat_err=1 (sticky); FSM returns to IDLE; the next burst completes normally.
- rst asserted in DATA after 1 of 8 beats -> all outputs at reset values immediately (async); after release, a new s1 request is granted normally.
